// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers for the E stage.
// Shift-add multiply or restoring divide at one bit per cycle, with stall generation for HI/LO hazards.
module muldiv_seq (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic        KILL,
  input  logic [31:0] SRC_A,
  input  logic [31:0] SRC_B,
  input  logic        RD_HILO,
  output logic        BUSY,
  output logic        STALL,
  output logic        DONE,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned ITER = 32;
  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 5;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state_q, state_nx;

  logic [W-1:0]   hi_q, lo_q;
  logic           busy_q, done_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   a_q, b_q, orig_a_q;
  logic           neg_q_q, neg_r_q, div0_q, is_div_q;
  logic [2*W-1:0] prod_q;
  logic [W:0]     rem_q;
  logic [W-1:0]   quot_q;

  logic           accept;
  logic           op_muldiv;
  logic           is_signed;
  logic [W-1:0]   a_in, b_in;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift, div_diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  assign accept    = START & ~KILL & (state_q == S_IDLE);
  assign op_muldiv = ~OP[2];
  assign is_signed = ~OP[0];

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign STALL = busy_q & (RD_HILO | (START & ~KILL));

  // Operand conditioning and one-bit iteration datapath
  always_comb begin
    a_in      = (is_signed & SRC_A[W-1]) ? -SRC_A : SRC_A;
    b_in      = (is_signed & SRC_B[W-1]) ? -SRC_B : SRC_B;
    mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : (W+1)'(0));
    div_shift = {rem_q[W-1:0], quot_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    prod_fix  = neg_q_q ? -prod_q : prod_q;
    quot_fix  = neg_q_q ? -quot_q : quot_q;
    rem_fix   = neg_r_q ? -rem_q[W-1:0] : rem_q[W-1:0];
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: if (accept && op_muldiv) state_nx = OP[1] ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:  if (cnt_q == CW'(ITER - 1)) state_nx = S_FIX;
      S_FIX:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and architectural HI/LO
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      orig_a_q <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      prod_q   <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
    end else begin
      busy_q <= (state_nx != S_IDLE);
      done_q <= (state_q == S_FIX);
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op_muldiv) begin
              a_q      <= a_in;
              b_q      <= b_in;
              orig_a_q <= SRC_A;
              neg_q_q  <= is_signed & (SRC_A[W-1] ^ SRC_B[W-1]);
              neg_r_q  <= is_signed & SRC_A[W-1];
              div0_q   <= OP[1] & (SRC_B == '0);
              is_div_q <= OP[1];
              prod_q   <= {{W{1'b0}}, b_in};
              rem_q    <= '0;
              quot_q   <= a_in;
              cnt_q    <= '0;
            end else if (OP == OP_MTHI) begin
              hi_q <= SRC_A;
            end else if (OP == OP_MTLO) begin
              lo_q <= SRC_A;
            end
          end
        end
        S_MUL: begin
          prod_q <= {mul_sum, prod_q[W-1:1]};
          cnt_q  <= cnt_q + CW'(1);
        end
        S_DIV: begin
          // Restore by keeping the shifted remainder when the trial subtract underflows
          if (div_diff[W]) begin
            rem_q  <= div_shift;
            quot_q <= {quot_q[W-2:0], 1'b0};
          end else begin
            rem_q  <= div_diff;
            quot_q <= {quot_q[W-2:0], 1'b1};
          end
          cnt_q <= cnt_q + CW'(1);
        end
        S_FIX: begin
          if (!is_div_q) begin
            hi_q <= prod_fix[2*W-1:W];
            lo_q <= prod_fix[W-1:0];
          end else if (div0_q) begin
            hi_q <= orig_a_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases with literal expectations plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [2:0]  OP = 3'd0;
  logic        KILL = 1'b0;
  logic [31:0] SRC_A = '0;
  logic [31:0] SRC_B = '0;
  logic        RD_HILO = 1'b0;
  logic        BUSY, STALL, DONE;
  logic [31:0] HI, LO;

  muldiv_seq dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .KILL(KILL),
    .SRC_A(SRC_A), .SRC_B(SRC_B), .RD_HILO(RD_HILO),
    .BUSY(BUSY), .STALL(STALL), .DONE(DONE), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: results computed with plain arithmetic, delivered after a fixed delay
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        last_stall = 1'b0;

  task automatic model_accept();
    longint      sa, sb;
    logic [63:0] p;
    sa = $signed(SRC_A);
    sb = $signed(SRC_B);
    case (OP)
      3'd0: begin p = 64'(sa * sb); p_hi = p[63:32]; p_lo = p[31:0]; m_left = 33; end
      3'd1: begin p = {32'b0, SRC_A} * {32'b0, SRC_B}; p_hi = p[63:32]; p_lo = p[31:0]; m_left = 33; end
      3'd2: begin
        if (SRC_B == 0) begin p_lo = '1; p_hi = SRC_A; end
        else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
        m_left = 33;
      end
      3'd3: begin
        if (SRC_B == 0) begin p_lo = '1; p_hi = SRC_A; end
        else begin p_lo = SRC_A / SRC_B; p_hi = SRC_A % SRC_B; end
        m_left = 33;
      end
      3'd4: m_hi = SRC_A;
      3'd5: m_lo = SRC_A;
      default: ;
    endcase
  endtask

  always @(posedge CLK) begin
    if (RESET) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
      end else if (START && !KILL) begin
        model_accept();
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: compare registered outputs against the model, drive inputs, then check STALL
  task automatic cycle(input logic rst, input logic st, input logic kl, input logic rd,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    chk("BUSY", 32'(BUSY), 32'(m_left > 0));
    chk("DONE", 32'(DONE), 32'(m_done));
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    RESET = rst; START = st; KILL = kl; RD_HILO = rd; OP = op; SRC_A = a; SRC_B = b;
    #1;
    last_stall = STALL;
    chk("STALL", 32'(STALL), 32'((m_left > 0) && (rd || (st && !kl))));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
  endtask

  // Issue one op and wait (bounded) for DONE; hold RD_HILO / a second START if asked
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rd_hold, input logic st_hold, input logic [2:0] op2,
                        input logic [31:0] a2, output int lat, output int stall_cnt);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, op, a, b);
    lat = 0;
    stall_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b0, st_hold, 1'b0, rd_hold, op2, a2, '0);
      if (last_stall) stall_cnt++;
      if (DONE) begin lat = k; break; end
    end
    chk("latency", 32'(lat), 32'd34);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, sc, dn;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    chk("reset_stall", 32'(STALL), 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 3'd0, '0, lat, sc);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFEB);
    chk("mult_done", 32'(DONE), 32'd1);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd0, '0, lat, sc);
    chk("multu_hi", HI, 32'hFFFF_FFFE);
    chk("multu_lo", LO, 32'h0000_0001);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 3'd0, '0, lat, sc);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd0, '0, lat, sc);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'h0);

    run_op(3'd3, 32'd100, 32'd0, 1'b0, 1'b0, 3'd0, '0, lat, sc);
    chk("div0_lo", LO, 32'hFFFF_FFFF);
    chk("div0_hi", HI, 32'h0000_0064);
    chk("div0_done", 32'(DONE), 32'd1);
    idle();
    chk("done_pulse", 32'(DONE), 32'd0);

    // MULTU with MFHI held and a queued MTHI re-presented through the whole operation
    run_op(3'd1, 32'd5, 32'd6, 1'b1, 1'b1, 3'd4, 32'hAAAA_5555, lat, sc);
    chk("stall_cycles", 32'(sc), 32'd33);
    chk("stall_rel", 32'(last_stall), 32'd0);
    chk("mulstall_lo", LO, 32'd30);
    chk("mulstall_hi", HI, 32'd0);
    idle();
    chk("queued_mthi", HI, 32'hAAAA_5555);

    cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 32'h1234_5678, '0);
    idle();
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_busy", 32'(BUSY), 32'd0);
    chk("mthi_done", 32'(DONE), 32'd0);

    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 32'hDEAD_BEEF, '0);
    chk("kill_stall", 32'(STALL), 32'd0);
    idle();
    chk("kill_lo", LO, 32'd30);
    chk("kill_busy", 32'(BUSY), 32'd0);

    // Reset in the middle of a divide aborts it
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 32'd1000, 32'd7);
    repeat (9) idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
    idle();
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (DONE) dn++;
    end
    chk("abort_nodone", 32'(dn), 32'd0);

    // Randomized traffic, including KILL and re-presented START during BUSY
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 500) == 0, ($urandom % 3) == 0, ($urandom % 8) == 0,
            ($urandom % 4) == 0, 3'($urandom % 8), pick(), pick());
    end
    repeat (40) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer that owns the architectural HI/LO registers for the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and runs a 1-bit-per-cycle shift-add multiply or restoring divide. It raises STALL when E issues a HI/LO read or a new HI/LO op while an operation is in flight. HI/LO feed the E-stage MFHI/MFLO path.

Parameters:
ITER, 32, iteration count; equals operand width, fixed at 32.

Ports:
CLK  in  1  clock
RESET  in  1  reset, synchronous, active-high; clock CLK
START  in  1  E-stage instruction is a HI/LO-writing op
OP  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 ignored (no action)
KILL  in  1  E-stage instruction flushed this cycle; suppresses START
SRC_A  in  32  forwarded rs (multiplicand / dividend / MTHI-MTLO data)
SRC_B  in  32  forwarded rt (multiplier / divisor)
RD_HILO  in  1  E-stage MFHI/MFLO present
BUSY  out  1  operation in flight (state != IDLE)
STALL  out  1  freeze E and earlier stages
DONE  out  1  one-cycle pulse: HI/LO just updated by MUL/DIV
HI  out  32  HI register
LO  out  32  LO register

Behaviour:
- Reset: state IDLE; HI=LO=0; BUSY=STALL=DONE=0; iteration counter=0. Reset mid-operation aborts it with no HI/LO write.
- Accept: an op is accepted on a rising edge where START & ~KILL & ~BUSY. START with BUSY=1 is not accepted; E holds and re-presents it.
- STALL = BUSY & (RD_HILO | (START & ~KILL)). STALL is combinational and is 0 whenever BUSY=0.
- MTHI/MTLO: on the accept edge, HI (or LO) <= SRC_A. The new value is visible the next cycle. BUSY stays 0 and DONE stays 0.
- States: IDLE -> MUL | DIV -> FIX -> IDLE.
- Accept edge T0:
  - Latch |A| and |B|: magnitudes for signed ops, raw values for unsigned.
  - Latch neg_q = sign(A)^sign(B) and neg_r = sign(A) for signed ops; both are 0 for unsigned.
  - Latch div0 = (SRC_B==0) for DIV/DIVU.
  - Counter=0; enter MUL or DIV.
- MUL: one shift-add step per edge on a 64-bit product. At T1..T32, counter increments 0..31. The edge with counter==31 moves to FIX.
- DIV: restoring division, one quotient bit per edge. Remainder is 33-bit and quotient 32-bit. Same counting as MUL.
- FIX (edge T33) sets the results and returns to IDLE:
  - MUL: {HI,LO} <= neg_q ? -product : product (64-bit two's complement).
  - DIV: LO <= neg_q ? -quot : quot; HI <= neg_r ? -rem : rem.
  - div0 overrides: LO <= 32'hFFFFFFFF, HI <= original SRC_A. Latency is unchanged.
  - Signed overflow 0x80000000 / 0xFFFFFFFF needs no special case and yields LO=0x80000000, HI=0.
- Latency: BUSY=1 in the cycles after T0 through T33 (33 cycles). In the cycle after T33: BUSY=0, DONE=1, new HI/LO visible, STALL released. An MFHI stalled through the operation reads the new value that cycle.
- DONE: registered, asserted exactly one cycle after the FIX edge; never asserted for MT ops or after reset.
- A new START may be accepted in the DONE cycle. HI/LO outputs are driven only from the registers, never from the iteration datapath.
- KILL with BUSY=1 does not abort the in-flight op; the op was committed at T0.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> BUSY 33 cycles, DONE 1 cycle later, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- DIVU A=100, B=0 -> after same 33-cycle BUSY: LO=0xFFFFFFFF, HI=0x00000064, DONE=1.
- MULTU 5*6, then RD_HILO=1 held from T0+1 -> STALL=1 every BUSY cycle; STALL=0 in DONE cycle with LO=30, HI=0. A second START during BUSY -> STALL=1, not accepted until DONE cycle.
- MTHI 0x12345678 with BUSY=0 -> next cycle HI=0x12345678, BUSY=0, DONE=0. START=1 with KILL=1 -> no state change, STALL=0.
- DIV running, RESET at T0+10 -> next cycle BUSY=0, HI=LO=0, DONE=0; DONE never pulses for the aborted op.
